// File: rtl/sssp_result_drain_if.sv
// Result stream from the SSSP drain: one distance beat per valid/ready transfer,
// tagged as unreachable, negative-cycle status, or final beat.
interface sssp_result_drain_if #(
  parameter int unsigned DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              inf;
  logic              neg;
  logic              last;

  modport master (output valid, data, inf, neg, last, input ready);
  modport slave  (input valid, data, inf, neg, last, output ready);
endinterface

// File: rtl/sssp_result_drain.sv
// Walks the distance memory after the solver finishes and streams each entry out,
// or emits a single negative-cycle status beat instead.
module sssp_result_drain #(
  parameter int unsigned      ADDR_W     = 14,
  parameter int unsigned      DATA_W     = 16,
  parameter int unsigned      START_ADDR = 0,
  parameter int unsigned      MAX_COUNT  = 16383,
  parameter logic [DATA_W-1:0] INF_VALUE  = 16'hFFFF,
  parameter logic [DATA_W-1:0] TERM_VALUE = 16'h0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                n_exist_i,
  output logic                mem_rd_en_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [DATA_W-1:0]   mem_rd_data_i,
  output logic                busy_o,
  output logic                done_o,
  sssp_result_drain_if.master out_if
);

  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(MAX_COUNT - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StHold, StNeg, StDone} state_e;

  state_e              state_q, state_d;
  logic                start_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_word;

  // Terminator word or the final permitted index both end the drain.
  assign last_word = (data_q == TERM_VALUE) || (idx_q == LastIdx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      addr_q  <= StartAddr;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        // n_exist is only looked at here, so later changes cannot affect this drain.
        if (start_i && !start_q) begin
          if (n_exist_i) begin
            state_d = StNeg;
          end else begin
            state_d = StRead;
            addr_d  = StartAddr;
            idx_d   = '0;
          end
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        data_d  = mem_rd_data_i;
        state_d = StHold;
      end
      StHold: begin
        if (out_if.ready) begin
          if (last_word) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StNeg: if (out_if.ready) state_d = StDone;
      StDone: if (!start_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_rd_en_o  = (state_q == StRead);
  assign mem_addr_o   = addr_q;
  assign busy_o       = (state_q == StRead) || (state_q == StWait) ||
                        (state_q == StHold) || (state_q == StNeg);
  assign done_o       = (state_q == StDone);
  assign out_if.valid = (state_q == StHold) || (state_q == StNeg);
  assign out_if.data  = (state_q == StHold) ? data_q : '0;
  assign out_if.inf   = (state_q == StHold) && (data_q == INF_VALUE);
  assign out_if.neg   = (state_q == StNeg);
  assign out_if.last  = ((state_q == StHold) && last_word) || (state_q == StNeg);

endmodule

// File: tb/tb_sssp_result_drain.sv
// Directed bench for sssp_result_drain with a synchronous distance-memory model.
module tb_sssp_result_drain;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        n_exist_i;
  logic        mem_rd_en;
  logic [13:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        busy, done;

  sssp_result_drain_if #(.DATA_W(16)) bus ();

  sssp_result_drain dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .n_exist_i    (n_exist_i),
    .mem_rd_en_o  (mem_rd_en),
    .mem_addr_o   (mem_addr),
    .mem_rd_data_i(mem_rdata),
    .busy_o       (busy),
    .done_o       (done),
    .out_if       (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] mem [16384];
  always @(posedge clk_i) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct packed {logic neg; logic last; logic inf; logic [15:0] data;} beat_t;
  beat_t       beats[$];
  logic [13:0] reads[$];

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.valid && bus.ready) beats.push_back({bus.neg, bus.last, bus.inf, bus.data});
      if (mem_rd_en) reads.push_back(mem_addr);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk_i); n++; end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int cnt, input int budget);
    int n = 0;
    while (beats.size() < cnt && n < budget) begin @(negedge clk_i); n++; end
    chk(tag, {31'd0, beats.size() >= cnt}, 32'd1);
  endtask

  task automatic start_drain(input logic neg);
    @(posedge clk_i); #1;
    n_exist_i = neg;
    start_i   = 1'b1;
  endtask

  task automatic stop_start();
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic load_t1();
    mem[0] = 16'h0005; mem[1] = 16'hFFFF; mem[2] = 16'h0003; mem[3] = 16'h0000;
  endtask

  function automatic logic [31:0] bt(input logic neg, last, inf, input logic [15:0] d);
    return {13'd0, neg, last, inf, d};
  endfunction

  task automatic check_t1(input string tag, input int base);
    chk({tag, "_b0"}, 32'(beats[base+0]), bt(0, 0, 0, 16'h0005));
    chk({tag, "_b1"}, 32'(beats[base+1]), bt(0, 0, 1, 16'hFFFF));
    chk({tag, "_b2"}, 32'(beats[base+2]), bt(0, 0, 0, 16'h0003));
    chk({tag, "_b3"}, 32'(beats[base+3]), bt(0, 1, 0, 16'h0000));
  endtask

  initial begin
    int  nlast;
    int  maxrd;
    bit  stable;
    int  n;

    rst_ni = 1'b0; start_i = 1'b0; n_exist_i = 1'b0; bus.ready = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0001;
    load_t1();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outs", {busy, done, mem_rd_en, bus.valid, bus.neg, bus.last, bus.inf},
        32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // 1: basic drain with terminator, plus first-beat latency
    bus.ready = 1'b1;
    start_drain(1'b0);
    repeat (2) @(negedge clk_i);
    chk("t1_rd_first", {31'd0, mem_rd_en}, 32'd1);
    @(negedge clk_i);
    chk("t1_valid_early", {31'd0, bus.valid}, 32'd0);
    @(negedge clk_i);
    chk("t1_valid_3cyc", {31'd0, bus.valid}, 32'd1);
    wait_done("t1_done", 40);
    chk("t1_nbeats", 32'(beats.size()), 32'd4);
    if (beats.size() == 4) check_t1("t1", 0);
    chk("t1_nreads", 32'(reads.size()), 32'd4);
    for (int i = 0; i < reads.size() && i < 4; i++) chk("t1_rdaddr", 32'(reads[i]), 32'(i));
    chk("t1_busy", {31'd0, busy}, 32'd0);
    stop_start();
    chk("t1_done_clr", {31'd0, done}, 32'd0);

    // 2: negative cycle; n_exist dropped right after the edge must not matter
    beats.delete(); reads.delete();
    start_drain(1'b1);
    @(posedge clk_i); #1 n_exist_i = 1'b0;
    wait_done("t2_done", 20);
    chk("t2_nbeats", 32'(beats.size()), 32'd1);
    if (beats.size() == 1) chk("t2_beat", 32'(beats[0]), bt(1, 1, 0, 16'h0000));
    chk("t2_noreads", 32'(reads.size()), 32'd0);
    stop_start();

    // 3: backpressure while the FFFF beat is presented
    beats.delete(); reads.delete();
    start_drain(1'b0);
    wait_beats("t3_first", 1, 20);
    @(posedge clk_i); #1 bus.ready = 1'b0;
    n = 0;
    while (!bus.valid && n < 20) begin @(negedge clk_i); n++; end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.valid && bus.data == 16'hFFFF && bus.inf && mem_addr == 14'd1 && !mem_rd_en))
        stable = 1'b0;
      @(negedge clk_i);
    end
    chk("t3_stable", {31'd0, stable}, 32'd1);
    chk("t3_held_cnt", 32'(beats.size()), 32'd1);
    @(posedge clk_i); #1 bus.ready = 1'b1;
    wait_done("t3_done", 40);
    chk("t3_nbeats", 32'(beats.size()), 32'd4);
    if (beats.size() == 4) check_t1("t3", 0);
    stop_start();

    // 4: no terminator, drain stops at MAX_COUNT entries
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0001;
    beats.delete(); reads.delete();
    start_drain(1'b0);
    wait_done("t4_done", 60000);
    chk("t4_nbeats", 32'(beats.size()), 32'd16383);
    nlast = 0;
    foreach (beats[i]) if (beats[i].last) nlast++;
    chk("t4_nlast", 32'(nlast), 32'd1);
    if (beats.size() > 0) chk("t4_lastflag", {31'd0, beats[beats.size()-1].last}, 32'd1);
    maxrd = 0;
    foreach (reads[i]) if (int'(reads[i]) > maxrd) maxrd = int'(reads[i]);
    chk("t4_maxread", 32'(maxrd), 32'd16382);
    chk("t4_nreads", 32'(reads.size()), 32'd16383);
    stop_start();

    // 5: reset after the 10th accept, then a fresh drain from address 0
    mem[20] = 16'h0000;
    beats.delete(); reads.delete();
    start_drain(1'b0);
    wait_beats("t5_ten", 10, 100);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    chk("t5_rst_outs", {busy, done, mem_rd_en, bus.valid, bus.neg, bus.last, bus.inf},
        32'd0);
    chk("t5_rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    beats.delete(); reads.delete();
    start_drain(1'b0);
    wait_done("t5_done", 200);
    chk("t5_nbeats", 32'(beats.size()), 32'd21);
    if (reads.size() > 0) chk("t5_rd0", 32'(reads[0]), 32'd0);
    if (beats.size() == 21) chk("t5_lastbeat", 32'(beats[20]), bt(0, 1, 0, 16'h0000));

    // 6: start held high after done must not retrigger
    stop_start();
    load_t1();
    beats.delete(); reads.delete();
    start_drain(1'b0);
    wait_done("t6_done1", 40);
    repeat (10) @(negedge clk_i);
    chk("t6_hold_reads", 32'(reads.size()), 32'd4);
    chk("t6_hold_done", {30'd0, done, busy}, 32'd2);
    stop_start();
    start_drain(1'b0);
    wait_done("t6_done2", 40);
    chk("t6_nbeats", 32'(beats.size()), 32'd8);
    if (beats.size() == 8) check_t1("t6_2nd", 4);
    stop_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
